// File: rtl/brush_writer_if.sv
// Signal bundle for brush_writer: the paint-request handshake plus the Avalon-MM word
// port. The block connects through the slave modport; its environment uses master.
interface brush_writer_if;
  // Request handshake: a request transfers on a rising clock edge where req_valid and
  // req_ready are both high; req_* and screen_ptr are only meaningful in that cycle.
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic [1:0]  req_t;
  logic [1:0]  req_radius;
  logic [31:0] screen_ptr;
  logic        busy;
  logic        done;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;
  logic [2:0]  dbg_state;

  modport master (
    output req_valid, req_x, req_y, req_t, req_radius, screen_ptr,
    output mem_waitrequest, mem_readdatavalid, mem_readdata,
    input  req_ready, busy, done,
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  dbg_state
  );

  modport slave (
    input  req_valid, req_x, req_y, req_t, req_radius, screen_ptr,
    input  mem_waitrequest, mem_readdatavalid, mem_readdata,
    output req_ready, busy, done,
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output dbg_state
  );
endinterface

// File: rtl/brush_writer.sv
// Paints a square (or, with BRUSH_WRITER_ROUND_EN defined, circular) brush of 2-bit cells
// into a packed framebuffer using one Avalon read-modify-write per touched word.
module brush_writer #(
  parameter int GRID_W        = 640,
  parameter int GRID_H        = 480,
  parameter int WORDS_PER_ROW = 40
) (
  input  logic clock,
  input  logic reset,
  brush_writer_if.slave bus
);

  localparam int WW = $clog2(WORDS_PER_ROW);
  localparam int CW = WW + 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    WR_REQ  = 3'd4,
    NEXT    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  r_q, r_d;
  logic [1:0]  t_q, t_d;
  logic [23:0] ptr_q, ptr_d;
  logic [9:0]  x0_q, x0_d;
  logic [9:0]  x1_q, x1_d;
  logic [9:0]  y1_q, y1_d;
  logic [9:0]  row_q, row_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;

  logic [10:0] x_sum, y_sum;
  logic [9:0]  x_lo, x_hi, y_lo, y_hi;
  logic [WW-1:0] word_first, word_last;
  logic [31:0] mask;
  logic [31:0] fill;
  logic [23:0] cur_addr;
  logic [CW-1:0] col;
  logic        inside_c;
  logic        unused_ptr_hi;

  // Clip the brush bounds to the grid using the latched request.
  always_comb begin
    x_sum = {1'b0, x_q} + {9'd0, r_q};
    y_sum = {1'b0, y_q} + {9'd0, r_q};
    x_lo  = (x_q >= {8'd0, r_q}) ? (x_q - {8'd0, r_q}) : 10'd0;
    y_lo  = (y_q >= {8'd0, r_q}) ? (y_q - {8'd0, r_q}) : 10'd0;
    x_hi  = (x_sum > 11'(GRID_W - 1)) ? 10'(GRID_W - 1) : x_sum[9:0];
    y_hi  = (y_sum > 11'(GRID_H - 1)) ? 10'(GRID_H - 1) : y_sum[9:0];
  end

  assign word_first = WW'(x0_q >> 4);
  assign word_last  = WW'(x1_q >> 4);
  assign cur_addr   = ptr_q + 24'(row_q) * 24'(WORDS_PER_ROW) + 24'(word_q);
  assign fill       = {16{t_q}};

  // Per-cell mask for the current word; each cell owns two adjacent bits.
  always_comb begin
    mask     = '0;
    col      = '0;
    inside_c = 1'b0;
    for (int c = 0; c < 16; c++) begin
      col      = {word_q, 4'(c)};
      inside_c = (col >= CW'(x0_q)) && (col <= CW'(x1_q));
`ifdef BRUSH_WRITER_ROUND_EN
      if (((int'(col) - int'(x_q)) * (int'(col) - int'(x_q)) +
           (int'(row_q) - int'(y_q)) * (int'(row_q) - int'(y_q))) > (int'(r_q) * int'(r_q)))
        inside_c = 1'b0;
`endif
      mask[2*c +: 2] = {2{inside_c}};
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    t_d     = t_q;
    ptr_d   = ptr_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    row_d   = row_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          x_d   = bus.req_x;
          y_d   = bus.req_y;
          r_d   = bus.req_radius;
          t_d   = bus.req_t;
          ptr_d = bus.screen_ptr[23:0];
          // Off-grid centres complete immediately without touching memory.
          if ((bus.req_x >= 10'(GRID_W)) || (bus.req_y >= 10'(GRID_H)))
            done_d = 1'b1;
          else
            state_d = SETUP;
        end
      end
      SETUP: begin
        x0_d    = x_lo;
        x1_d    = x_hi;
        y1_d    = y_hi;
        row_d   = y_lo;
        word_d  = WW'(x_lo >> 4);
        state_d = RD_REQ;
      end
      RD_REQ: begin
        if (!bus.mem_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_readdatavalid) begin
          wdata_d = (bus.mem_readdata & ~mask) | (fill & mask);
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!bus.mem_waitrequest) state_d = NEXT;
      end
      NEXT: begin
        if (word_q != word_last) begin
          word_d  = word_q + 1'b1;
          state_d = RD_REQ;
        end else if (row_q != y1_q) begin
          row_d   = row_q + 10'd1;
          word_d  = word_first;
          state_d = RD_REQ;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      ptr_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      row_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      t_q     <= t_d;
      ptr_q   <= ptr_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      row_q   <= row_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = done_q;
  assign bus.mem_read       = (state_q == RD_REQ);
  assign bus.mem_write      = (state_q == WR_REQ);
  assign bus.mem_address    = cur_addr;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = 4'hF;
  assign bus.dbg_state      = state_q;
  assign unused_ptr_hi      = ^bus.screen_ptr[31:24];

endmodule

// File: tb/tb_brush_writer.sv
// Bench for brush_writer: Avalon memory responder, cell-level reference model feeding
// expected-access queues, and a monitor that checks every accepted read and write.
module tb_brush_writer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  brush_writer_if bus();

  brush_writer #(.GRID_W(640), .GRID_H(480), .WORDS_PER_ROW(40)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  logic [23:0] exp_rd_q[$];
  logic [23:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  logic [23:0] rd_log_q[$];
  logic [23:0] wa_log_q[$];
  logic [31:0] wd_log_q[$];
  logic [31:0] bus_mem [logic [23:0]];
  logic [31:0] ref_mem [logic [23:0]];
  int rd_count = 0;
  int wr_count = 0;

  int          init_mode  = 0;
  logic [31:0] init_const = 32'h0;
  bit stall_force = 1'b0;
  bit rand_en     = 1'b0;
  bit spur_en     = 1'b0;
  int lat_force   = -1;

  function automatic logic [31:0] init_val(logic [23:0] a);
    if (init_mode == 0) return init_const;
    return ({8'h0, a} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic new_memory(int mode, logic [31:0] c);
    init_mode  = mode;
    init_const = c;
    bus_mem.delete();
    ref_mem.delete();
    rd_log_q.delete();
    wa_log_q.delete();
    wd_log_q.delete();
  endtask

  // Reference model: paint each brush cell into a word-level copy of memory.
  task automatic model_req(int x, int y, int r, int t, logic [31:0] ptr);
    int x0, x1, y0, y1;
    logic [23:0] a;
    logic [31:0] v;
    bit in_brush;
    if (x >= 640 || y >= 480) return;
    x0 = (x - r < 0) ? 0 : x - r;
    y0 = (y - r < 0) ? 0 : y - r;
    x1 = (x + r > 639) ? 639 : x + r;
    y1 = (y + r > 479) ? 479 : y + r;
    for (int row = y0; row <= y1; row++) begin
      for (int w = x0 / 16; w <= x1 / 16; w++) begin
        a = ptr[23:0] + 24'(row * 40 + w);
        v = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        for (int col = w * 16; col < w * 16 + 16; col++) begin
          in_brush = (col >= x0) && (col <= x1);
`ifdef BRUSH_WRITER_ROUND_EN
          if ((col - x) * (col - x) + (row - y) * (row - y) > r * r) in_brush = 1'b0;
`endif
          if (in_brush) v[2 * (col % 16) +: 2] = 2'(t);
        end
        ref_mem[a] = v;
        exp_rd_q.push_back(a);
        exp_wa_q.push_back(a);
        exp_wd_q.push_back(v);
      end
    end
  endtask

  // Memory responder: one read outstanding, variable latency, random stalls.
  bit          pend = 1'b0;
  logic [23:0] pend_addr;
  int          pend_lat;
  initial begin
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata      = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.mem_read && !bus.mem_waitrequest) begin
          pend      = 1'b1;
          pend_addr = bus.mem_address;
          pend_lat  = (lat_force >= 0) ? lat_force : (rand_en ? int'($urandom_range(0, 3)) : 0);
        end
        if (bus.mem_write && !bus.mem_waitrequest) bus_mem[bus.mem_address] = bus.mem_writedata;
      end
      @(posedge clock);
      #1;
      bus.mem_readdatavalid = 1'b0;
      bus.mem_readdata      = $urandom;
      if (pend) begin
        if (pend_lat == 0) begin
          bus.mem_readdatavalid = 1'b1;
          bus.mem_readdata = bus_mem.exists(pend_addr) ? bus_mem[pend_addr] : init_val(pend_addr);
          pend = 1'b0;
        end else begin
          pend_lat--;
        end
      end else if (spur_en && $urandom_range(0, 4) == 0) begin
        bus.mem_readdatavalid = 1'b1;
      end
      bus.mem_waitrequest = stall_force ? 1'b1 : (rand_en ? ($urandom_range(0, 2) == 0) : 1'b0);
    end
  end

  // Monitor: every accepted access is popped against the expected queues.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.mem_read || bus.mem_write)
          check("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'h0);
        if (bus.mem_read && !bus.mem_waitrequest) begin
          rd_count++;
          rd_log_q.push_back(bus.mem_address);
          check("rd_expected", 32'(exp_rd_q.size() > 0), 32'h1);
          if (exp_rd_q.size() > 0)
            check("rd_addr", {8'h0, bus.mem_address}, {8'h0, exp_rd_q.pop_front()});
        end
        if (bus.mem_write && !bus.mem_waitrequest) begin
          wr_count++;
          wa_log_q.push_back(bus.mem_address);
          wd_log_q.push_back(bus.mem_writedata);
          check("wr_byteenable", 32'(bus.mem_byteenable), 32'hF);
          check("wr_expected", 32'(exp_wa_q.size() > 0), 32'h1);
          if (exp_wa_q.size() > 0) begin
            check("wr_addr", {8'h0, bus.mem_address}, {8'h0, exp_wa_q.pop_front()});
            check("wr_data", bus.mem_writedata, exp_wd_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_req(int x, int y, int r, int t, logic [31:0] ptr);
    int n;
    @(posedge clock);
    #1;
    bus.req_x      = 10'(x);
    bus.req_y      = 10'(y);
    bus.req_radius = 2'(r);
    bus.req_t      = 2'(t);
    bus.screen_ptr = ptr;
    bus.req_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.req_ready) break;
      n++;
      if (n > 200) begin
        check("req_accept_timeout", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b0;
        return;
      end
    end
    model_req(x, y, r, t, ptr);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.done) break;
      n++;
      if (n > budget) begin
        check("done_timeout", 32'(bus.done), 32'h1);
        return;
      end
    end
    @(negedge clock);
    check("done_one_cycle", 32'(bus.done), 32'h0);
    check("queues_drained", 32'(exp_rd_q.size() + exp_wa_q.size()), 32'h0);
  endtask

  task automatic run_req(int x, int y, int r, int t, logic [31:0] ptr);
    send_req(x, y, r, t, ptr);
    @(negedge clock);
    if (x >= 640 || y >= 480) begin
      check("oor_done_next_cycle", 32'(bus.done), 32'h1);
      @(negedge clock);
      check("oor_done_one_cycle", 32'(bus.done), 32'h0);
    end else begin
      check("busy_after_accept", 32'(bus.busy), 32'h1);
      wait_done(3000);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_mem_read"}, 32'(bus.mem_read), 32'h0);
    check({tag, "_mem_write"}, 32'(bus.mem_write), 32'h0);
    check({tag, "_mem_address"}, {8'h0, bus.mem_address}, 32'h0);
    check({tag, "_mem_writedata"}, bus.mem_writedata, 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rx, ry;
    logic [23:0] a0;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_t      = '0;
    bus.req_radius = '0;
    bus.screen_ptr = '0;

    // Power-on reset
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);
    check("reset_req_ready", 32'(bus.req_ready), 32'h1);

    // Single cell
    rand_en = 1'b1;
    new_memory(0, 32'h0);
    run_req(100, 50, 0, 1, 32'h1000);
    check("s1_rd_count", 32'(rd_log_q.size()), 32'h1);
    if (rd_log_q.size() > 0) check("s1_rd_addr", {8'h0, rd_log_q[0]}, 32'h17D6);
    if (wd_log_q.size() > 0) check("s1_wr_data", wd_log_q[0], 32'h100);

    // Corner clip
    new_memory(0, 32'hFFFF0000);
    run_req(0, 0, 3, 3, 32'h0);
`ifndef BRUSH_WRITER_ROUND_EN
    check("s2_wr_count", 32'(wd_log_q.size()), 32'h4);
    for (int i = 0; i < 4 && i < wd_log_q.size(); i++) begin
      check("s2_wr_addr", {8'h0, wa_log_q[i]}, 32'(40 * i));
      check("s2_wr_data", wd_log_q[i], 32'hFFFF00FF);
    end
`endif

    // Word-boundary straddle
    new_memory(0, 32'h0);
    run_req(15, 10, 1, 3, 32'h0);
`ifndef BRUSH_WRITER_ROUND_EN
    check("s3_wr_count", 32'(wd_log_q.size()), 32'h6);
    for (int i = 0; i < 6 && i < wd_log_q.size(); i++)
      check("s3_wr_data", wd_log_q[i], (i % 2 == 0) ? 32'hF0000000 : 32'h00000003);
`endif

    // Read held under waitrequest
    rand_en = 1'b0;
    new_memory(1, 32'h0);
    rd_count = 0;
    stall_force = 1'b1;
    send_req(300, 200, 0, 2, 32'h00ABCDEF);
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.mem_read) break;
      n++;
      if (n > 50) begin
        check("stall_read_seen", 32'(bus.mem_read), 32'h1);
        break;
      end
    end
    a0 = bus.mem_address;
    check("stall_addr", {8'h0, a0}, {8'h0, 24'h00ABCDEF + 24'(200 * 40 + 300 / 16)});
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_read_held", 32'(bus.mem_read), 32'h1);
      check("stall_addr_held", {8'h0, bus.mem_address}, {8'h0, a0});
    end
    stall_force = 1'b0;
    wait_done(200);
    check("stall_one_read", 32'(rd_count), 32'h1);

    // Off-grid requests
    rd_count = 0;
    wr_count = 0;
    run_req(700, 10, 2, 1, 32'h0);
    run_req(20, 480, 1, 2, 32'h0);
    check("oor_no_reads", 32'(rd_count), 32'h0);
    check("oor_no_writes", 32'(wr_count), 32'h0);

    // Reset while waiting for read data, then stale data returns
    lat_force = 6;
    send_req(200, 100, 0, 1, 32'h0);
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.mem_read && !bus.mem_waitrequest) break;
      n++;
      if (n > 50) begin
        check("rst_read_seen", 32'(bus.mem_read), 32'h1);
        break;
      end
    end
    @(posedge clock);
    #1;
    check("rst_in_rd_wait", 32'(bus.mem_read | bus.mem_write), 32'h0);
    reset = 1'b1;
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    wr_count = 0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("rst_no_write", 32'(wr_count), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    lat_force = -1;

    // Randomized requests against the reference model
    new_memory(1, 32'h0);
    rand_en = 1'b1;
    spur_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rx = ($urandom_range(0, 99) < 6) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
      ry = ($urandom_range(0, 99) < 6) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479));
      if ($urandom_range(0, 3) == 0)
        run_req(rx, ry, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {8'($urandom), 24'hFFFFFF - 24'($urandom_range(0, 3000))});
      else
        run_req(rx, ry, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end
    rand_en = 1'b0;
    spur_en = 1'b0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
